act_unit_pipe: RTL
==================

Name: act_unit_pipe

Overview:
- Multi-channel, mode-selectable activation stage for the feature datapath; successor to the single-lane ReLU register.
- Accepts CHANNELS signed two's-complement features per beat and applies one of four activation modes: bypass, ReLU, leaky ReLU, clamped ReLU.
- Returns results through a 2-stage pipeline with valid/ready flow control.
- Keeps a saturating count of zeroed outputs for sparsity statistics.

Parameters:
- FEATURE_WIDTH, 32, bit width of each signed feature lane.
- CHANNELS, 4, number of parallel lanes per beat.
- LEAK_SHIFT, 3, arithmetic right-shift used for the leaky slope (slope = 2^-LEAK_SHIFT).
- CNT_WIDTH, 16, width of the zero-count statistics counter.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, input beat accepted when in_valid && in_ready.
- in_data, input, CHANNELS*FEATURE_WIDTH, lane k at bits [k*FW +: FW].
- in_mode, input, 2, activation mode; sampled with the beat.
- clip_max, input, FEATURE_WIDTH, clamp ceiling for mode 3; sampled with the beat; treated as signed.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, CHANNELS*FEATURE_WIDTH, activated lanes, same packing as in_data.
- clr_stats, input, 1, synchronous clear of zero_count.
- zero_count, output, CNT_WIDTH, saturating count of output lanes equal to 0.

Behaviour:
- Reset (async, rst_n low): v1, v2, out_valid, out_data, zero_count and all stage registers go to 0. Any beats in flight are discarded. in_ready reads 1 after reset release.
- Modes, per lane, x signed:
  - 0 = BYPASS: y = x.
  - 1 = RELU: y = x if x[MSB]==0, else 0.
  - 2 = LEAKY: y = x if x >= 0, else x >>> LEAK_SHIFT (arithmetic; rounds toward -inf, so -1 stays -1).
  - 3 = CLAMP: y = 0 if x < 0; y = clip_max if x > clip_max; else x. If clip_max < 0, y = 0 for all x.
- Pipeline:
  - Stage 1 registers in_data, in_mode and clip_max.
  - Stage 2 registers the computed y into out_data.
  - Latency is exactly 2 cycles from acceptance to out_valid when out_ready stays 1.
  - Throughput is 1 beat/cycle.
- Flow control:
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1. This is a combinational path from out_ready; no skid buffer.
  - Stage registers hold their value when their stage does not advance.
  - out_data stays stable while out_valid && !out_ready.
- Mode and clip_max travel with each beat. Changing in_mode between beats never affects beats already accepted.
- Statistics:
  - When a beat leaves stage 2 (out_valid && out_ready), zero_count += the number of lanes with y == 0. Range is 0..CHANNELS.
  - zero_count saturates at 2^CNT_WIDTH-1.
  - clr_stats has priority over a same-cycle increment; the result is 0.
- No arithmetic widening: all outputs fit in FEATURE_WIDTH by construction, so no overflow path exists.
- Boundary cases:
  - Most-negative input: ReLU and CLAMP give 0; LEAKY gives -2^(FW-1-LEAK_SHIFT).
  - in_valid low gives no state change in stage 1.
  - Simultaneous output and input handshake while full is allowed without a bubble.

Decomposition:
- Shared package: mode encodings MODE_BYPASS=2'd0, MODE_RELU=2'd1, MODE_LEAKY=2'd2, MODE_CLAMP=2'd3; the mode width constant.
- Sub-module act_lane: purely combinational per-lane function (x, mode, clip_max) -> y, plus an is_zero flag. Instantiated CHANNELS times via generate.
- Popcount of is_zero flags and the pipeline/handshake logic stay in act_unit_pipe.

Test Plan:
- ReLU basic (mode 1), lanes {5, -3, 0, 0x7FFFFFFF}, out_ready=1 -> after 2 cycles out {5, 0, 0, 0x7FFFFFFF}; zero_count=2.
- Leaky (mode 2, LEAK_SHIFT=3), lanes {-16, -1, 0x80000000, 40} -> {-2, -1, 0xF0000000, 40}; zero_count unchanged.
- Clamp (mode 3, clip_max=100), lanes {150, 100, -7, 99} -> {100, 100, 0, 99}. Repeat with clip_max=-5 -> all 0; zero_count += 4.
- Backpressure: stream 6 beats while out_ready low for cycles 3-6:
  - in_ready drops once both stages are full.
  - out_data is held stable while stalled.
  - All 6 beats emerge in order with no loss or duplication.
- Per-beat mode: alternate mode 0/1 on consecutive beats with the same data {-4, 4, -4, 4} -> outputs alternate {-4, 4, -4, 4} / {0, 4, 0, 4}.
- Reset and stats:
  - Assert rst_n low mid-stream -> out_valid=0, zero_count=0 immediately.
  - With CNT_WIDTH=4, feed 5 all-zero beats -> zero_count=15 (saturated).
  - clr_stats together with an increment -> 0.

Source files
------------

// File: rtl/act_unit_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : act_unit_pipe_pkg
//  Brief    : Shared mode encodings for the multi-channel activation stage.
//  Revision : 1.0 - initial release
// ============================================================================
package act_unit_pipe_pkg;

  // Width of the per-beat activation mode field.
  localparam int MODE_W = 2;

  // Activation function selected per beat; travels with the data.
  typedef enum logic [MODE_W-1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLAMP  = 2'd3
  } act_mode_e;

endpackage : act_unit_pipe_pkg
`default_nettype wire

// File: rtl/act_lane.sv
`default_nettype none
// ============================================================================
//  Module   : act_lane
//  Brief    : Combinational single-lane activation (bypass/ReLU/leaky/clamp)
//             with a zero-result flag for sparsity statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module act_lane
  import act_unit_pipe_pkg::*;
#(
  parameter int FEATURE_WIDTH = 32,
  parameter int LEAK_SHIFT    = 3
) (
  input  logic [FEATURE_WIDTH-1:0] x,
  input  act_mode_e                mode,
  input  logic [FEATURE_WIDTH-1:0] clip_max,
  output logic [FEATURE_WIDTH-1:0] y,
  output logic                     is_zero
);

  logic signed [FEATURE_WIDTH-1:0] w_xs;
  logic signed [FEATURE_WIDTH-1:0] w_clip;
  logic signed [FEATURE_WIDTH-1:0] w_leak;

  assign w_xs   = $signed(x);
  assign w_clip = $signed(clip_max);
  // Arithmetic shift floors toward -inf, so -1 stays -1 and nothing overflows.
  assign w_leak = w_xs >>> LEAK_SHIFT;

  // Select the activation result for this lane.
  always_comb begin
    y = x;
    case (mode)
      MODE_BYPASS: y = x;
      MODE_RELU:   y = x[FEATURE_WIDTH-1] ? '0 : x;
      MODE_LEAKY:  y = x[FEATURE_WIDTH-1] ? w_leak : x;
      MODE_CLAMP: begin
        // A negative ceiling forces every lane to zero, positives included.
        if (w_clip[FEATURE_WIDTH-1] || x[FEATURE_WIDTH-1]) begin
          y = '0;
        end else if (w_xs > w_clip) begin
          y = clip_max;
        end else begin
          y = x;
        end
      end
    endcase
  end

  assign is_zero = (y == '0);

endmodule : act_lane
`default_nettype wire

// File: rtl/act_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : act_unit_pipe
//  Brief    : CHANNELS-lane activation stage, 2-stage valid/ready pipeline,
//             saturating count of zeroed output lanes.
//  Revision : 1.0 - initial release
// ============================================================================
module act_unit_pipe
  import act_unit_pipe_pkg::*;
#(
  parameter int FEATURE_WIDTH = 32,
  parameter int CHANNELS      = 4,
  parameter int LEAK_SHIFT    = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CHANNELS*FEATURE_WIDTH-1:0] in_data,
  input  logic [MODE_W-1:0]                 in_mode,
  input  logic [FEATURE_WIDTH-1:0]          clip_max,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CHANNELS*FEATURE_WIDTH-1:0] out_data,
  input  logic                              clr_stats,
  output logic [CNT_WIDTH-1:0]              zero_count
);

  localparam int c_DW   = CHANNELS * FEATURE_WIDTH;
  localparam int c_NZ_W = $clog2(CHANNELS + 1);
  localparam logic [CNT_WIDTH:0] c_CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

  // Stage 1: raw beat plus its own mode and ceiling.
  logic                     r_v1;
  logic [c_DW-1:0]          r_data1;
  act_mode_e                r_mode1;
  logic [FEATURE_WIDTH-1:0] r_clip1;

  // Stage 2: activated beat plus its zero-lane count.
  logic                     r_v2;
  logic [c_DW-1:0]          r_data2;
  logic [c_NZ_W-1:0]        r_nz2;

  logic [CNT_WIDTH-1:0]     r_zero_count;

  logic                     w_adv1;
  logic                     w_adv2;
  logic                     w_fire;
  logic [c_DW-1:0]          w_y;
  logic [CHANNELS-1:0]      w_zero;
  logic [c_NZ_W-1:0]        w_nz;
  logic [CNT_WIDTH:0]       w_sum;
  logic [CNT_WIDTH-1:0]     w_cnt_next;

  // No skid buffer: in_ready is combinational through both stages from out_ready.
  assign w_adv2   = !r_v2 || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign w_fire   = r_v2 && out_ready;
  assign in_ready = w_adv1;

  assign out_valid  = r_v2;
  assign out_data   = r_data2;
  assign zero_count = r_zero_count;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    act_lane #(
      .FEATURE_WIDTH (FEATURE_WIDTH),
      .LEAK_SHIFT    (LEAK_SHIFT)
    ) u_lane (
      .x        (r_data1[k*FEATURE_WIDTH +: FEATURE_WIDTH]),
      .mode     (r_mode1),
      .clip_max (r_clip1),
      .y        (w_y[k*FEATURE_WIDTH +: FEATURE_WIDTH]),
      .is_zero  (w_zero[k])
    );
  end

  // Count zeroed lanes of the beat about to enter stage 2.
  always_comb begin
    w_nz = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_nz = w_nz + c_NZ_W'(w_zero[i]);
    end
  end

  // Stage 1 register: loads only on an accepted beat, otherwise holds its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_data1 <= '0;
      r_mode1 <= MODE_BYPASS;
      r_clip1 <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_data1 <= in_data;
        r_mode1 <= act_mode_e'(in_mode);
        r_clip1 <= clip_max;
      end
    end
  end

  // Stage 2 register: holds the output stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_data2 <= '0;
      r_nz2   <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data2 <= w_y;
        r_nz2   <= w_nz;
      end
    end
  end

  assign w_sum      = {1'b0, r_zero_count} + (CNT_WIDTH+1)'(r_nz2);
  assign w_cnt_next = (w_sum > c_CNT_MAX) ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];

  // Saturating zero-lane counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_count <= '0;
    end else if (clr_stats) begin
      r_zero_count <= '0;
    end else if (w_fire) begin
      r_zero_count <= w_cnt_next;
    end
  end

endmodule : act_unit_pipe
`default_nettype wire
